// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//
// Debounces a bank of asynchronous, active-low key inputs and reports level
// changes to a downstream consumer as snapshot events over a valid/ready
// handshake.
//
// Each raw key is first passed through a two-flop synchronizer. A shared
// prescaler produces a one-cycle sample tick every TICK_DIV clocks. A key's
// debounced level only follows the synchronized level once it has differed
// on STABLE_TICKS consecutive ticks.
//
// Whenever the debounced vector differs from the last snapshot, a snapshot
// event is raised and held until it is accepted. Any debounced changes that
// arrive while a snapshot is still waiting are folded into the next snapshot.
// Those absorbed changes are counted in a saturating counter.
//
// Parameters
//   NUM_KEYS      number of key inputs (1..512)
//   TICK_DIV      clk_i cycles per sample tick (2..65535)
//   STABLE_TICKS  consecutive differing ticks needed to accept a level (1..255)
//
// Ports
//   clk_i            single clock, rising edge
//   rst_i            synchronous active-high reset
//   keys_i           raw key levels, asynchronous, 1 = released
//   keys_o           debounced key levels (registered)
//   evt_valid_o      snapshot event pending (registered)
//   evt_keys_o       snapshot of keys_o, stable while evt_valid_o = 1
//   evt_ready_i      downstream accepts the event
//   evt_coalesced_o  saturating count of changes absorbed into a pending event
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int NUM_KEYS     = 61,
    parameter int TICK_DIV     = 780,
    parameter int STABLE_TICKS = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_KEYS-1:0] keys_i,
    output logic [NUM_KEYS-1:0] keys_o,
    output logic                evt_valid_o,
    output logic [NUM_KEYS-1:0] evt_keys_o,
    input  logic                evt_ready_i,
    output logic [7:0]          evt_coalesced_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } evt_state_t;

    logic [NUM_KEYS-1:0]         sync1_r;
    logic [NUM_KEYS-1:0]         sync2_r;
    logic [PW-1:0]               presc_r;
    logic                        tick_s;
    logic [NUM_KEYS-1:0][CW-1:0] cnt_r;
    logic [NUM_KEYS-1:0][CW-1:0] cnt_nxt_s;
    logic [NUM_KEYS-1:0]         keys_r;
    logic [NUM_KEYS-1:0]         keys_nxt_s;
    logic                        keys_upd_s;
    evt_state_t                  state_r;
    evt_state_t                  state_nxt_s;
    logic [NUM_KEYS-1:0]         evt_keys_r;
    logic                        evt_load_s;
    logic                        coal_inc_s;
    logic [7:0]                  coal_r;

    // Two-flop synchronizer: the only logic that samples the raw key inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_r <= '1;
            sync2_r <= '1;
        end else begin
            sync1_r <= keys_i;
            sync2_r <= sync1_r;
        end
    end

    assign tick_s = (presc_r == PRESC_LAST);

    // Free-running sample prescaler, wraps to zero on the tick cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Per-key stability counting; the debounced level flips on the tick where
    // the counter has already seen STABLE_TICKS-1 differing ticks.
    always_comb begin
        keys_nxt_s = keys_r;
        cnt_nxt_s  = cnt_r;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (tick_s) begin
                if (sync2_r[k] == keys_r[k]) begin
                    cnt_nxt_s[k] = '0;
                end else if (cnt_r[k] == CNT_LAST) begin
                    keys_nxt_s[k] = sync2_r[k];
                    cnt_nxt_s[k]  = '0;
                end else begin
                    cnt_nxt_s[k] = cnt_r[k] + CW'(1);
                end
            end else begin
                cnt_nxt_s[k] = cnt_r[k];
            end
        end
    end

    assign keys_upd_s = (keys_nxt_s != keys_r);

    // Debounced level and stability counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            keys_r <= '1;
            cnt_r  <= '0;
        end else begin
            keys_r <= keys_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    // Event next-state logic. A transfer always drops to IDLE for one cycle;
    // if keys_o has moved on (before or on the transfer edge), IDLE sees the
    // difference immediately and re-enters PEND with a fresh snapshot. This
    // gives the required single low cycle of evt_valid_o without a third state.
    always_comb begin
        state_nxt_s = state_r;
        evt_load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (keys_r != evt_keys_r) begin
                    state_nxt_s = ST_PEND;
                    evt_load_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (evt_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PEND;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // A debounced change absorbed into an event that is not leaving this cycle.
    assign coal_inc_s = (state_r == ST_PEND) && !evt_ready_i && keys_upd_s;

    // Event state, snapshot and coalesced-change counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            evt_keys_r <= '1;
            coal_r     <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            if (evt_load_s) begin
                evt_keys_r <= keys_r;
            end else begin
                evt_keys_r <= evt_keys_r;
            end
            if (coal_inc_s && (coal_r != 8'hFF)) begin
                coal_r <= coal_r + 8'd1;
            end else begin
                coal_r <= coal_r;
            end
        end
    end

    assign keys_o          = keys_r;
    assign evt_valid_o     = (state_r == ST_PEND);
    assign evt_keys_o      = evt_keys_r;
    assign evt_coalesced_o = coal_r;

endmodule

// File: tb/tb_key_debounce.sv
// ---------------------------------------------------------------------------
// tb_key_debounce
//
// Self-checking bench for key_debounce with TICK_DIV=4, STABLE_TICKS=3 and
// NUM_KEYS=61. A behavioural model tracks inputs two cycles late, counts ticks
// by cycle number since reset, and counts consecutive differing ticks per key.
// It also keeps the pending snapshot, and every cycle the DUT outputs are
// compared against it. Directed scenarios are followed by a coalesce-
// saturation run and a randomized run.
// ---------------------------------------------------------------------------
module tb_key_debounce;

    localparam int NK = 61;
    localparam int TD = 4;
    localparam int ST = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] keys_in;
    logic [NK-1:0] keys_out;
    logic          evt_valid;
    logic [NK-1:0] evt_keys;
    logic          ready;
    logic [7:0]    coal;

    key_debounce #(
        .NUM_KEYS    (NK),
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .keys_i         (keys_in),
        .keys_o         (keys_out),
        .evt_valid_o    (evt_valid),
        .evt_keys_o     (evt_keys),
        .evt_ready_i    (ready),
        .evt_coalesced_o(coal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model state
    logic [NK-1:0] m_h0, m_h1;
    logic [NK-1:0] m_keys, m_evt;
    logic          m_valid;
    int            m_coal;
    int            m_cyc;
    int            m_run [NK];
    int            valid_cycles;

    // One clock: advance the model from pre-edge inputs, then compare after the edge.
    task automatic step();
        logic [NK-1:0] nk;
        bit            tick;
        if (rst) begin
            m_h0 = '1; m_h1 = '1; m_keys = '1; m_evt = '1;
            m_valid = 1'b0; m_coal = 0; m_cyc = 0;
            for (int k = 0; k < NK; k++) m_run[k] = 0;
        end else begin
            tick = ((m_cyc % TD) == TD - 1);
            nk = m_keys;
            if (tick) begin
                for (int k = 0; k < NK; k++) begin
                    if (m_h1[k] == m_keys[k]) begin
                        m_run[k] = 0;
                    end else begin
                        m_run[k]++;
                        if (m_run[k] == ST) begin
                            nk[k] = m_h1[k];
                            m_run[k] = 0;
                        end
                    end
                end
            end
            if (!m_valid) begin
                if (m_keys != m_evt) begin
                    m_valid = 1'b1;
                    m_evt = m_keys;
                end
            end else if (ready) begin
                m_valid = 1'b0;
            end else if ((nk != m_keys) && (m_coal < 255)) begin
                m_coal++;
            end
            m_keys = nk;
            m_h1 = m_h0;
            m_h0 = keys_in;
            m_cyc++;
        end
        @(posedge clk);
        #1;
        check_val("keys_o", 64'(keys_out), 64'(m_keys));
        check_val("evt_valid", 64'(evt_valid), 64'(m_valid));
        check_val("evt_keys", 64'(evt_keys), 64'(m_evt));
        check_val("coalesced", 64'(coal), 64'(m_coal));
        if (evt_valid) valid_cycles++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [NK-1:0] all_ones;
    int            split;
    int            idx;

    initial begin
        all_ones = '1;
        rst = 1'b1;
        ready = 1'b0;
        keys_in = '1;
        run(3);
        rst = 1'b0;

        // idle after reset
        valid_cycles = 0;
        run(100);
        check_val("idle_keys", 64'(keys_out), 64'(all_ones));
        check_val("idle_no_evt", 64'(valid_cycles), 64'd0);
        check_val("idle_coal", 64'(coal), 64'd0);

        // single key press, accepted immediately
        ready = 1'b1;
        keys_in[5] = 1'b0;
        valid_cycles = 0;
        run(30);
        check_val("k5_level", 64'(keys_out[5]), 64'd0);
        check_val("k5_snap", 64'(evt_keys[5]), 64'd0);
        check_val("k5_one_evt", 64'(valid_cycles), 64'd1);
        keys_in[5] = 1'b1;
        run(30);

        // short glitch is rejected
        valid_cycles = 0;
        keys_in[9] = 1'b0;
        run(6);
        keys_in[9] = 1'b1;
        run(30);
        check_val("glitch_no_evt", 64'(valid_cycles), 64'd0);
        check_val("glitch_level", 64'(keys_out[9]), 64'd1);

        // two keys in the same cycle -> same edge, one event
        valid_cycles = 0;
        split = 0;
        keys_in[0] = 1'b0;
        keys_in[60] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (keys_out[0] !== keys_out[60]) split = 1;
        end
        check_val("same_edge", 64'(split), 64'd0);
        check_val("pair_one_evt", 64'(valid_cycles), 64'd1);
        check_val("pair_level", 64'({keys_out[60], keys_out[0]}), 64'd0);
        keys_in[0] = 1'b1;
        keys_in[60] = 1'b1;
        run(30);

        // coalescing while the consumer stalls
        ready = 1'b0;
        keys_in[1] = 1'b0;
        run(25);
        keys_in[2] = 1'b0;
        run(25);
        check_val("coal_valid", 64'(evt_valid), 64'd1);
        check_val("coal_snap", 64'(evt_keys[2:1]), 64'b10);
        check_val("coal_cnt", 64'(coal), 64'd1);
        ready = 1'b1;
        step();
        check_val("coal_gap", 64'(evt_valid), 64'd0);
        ready = 1'b0;
        step();
        check_val("coal_reassert", 64'(evt_valid), 64'd1);
        check_val("coal_resnap", 64'(evt_keys[2:1]), 64'b00);
        ready = 1'b1;
        run(5);

        // reset while pending and mid-debounce
        ready = 1'b0;
        keys_in[1] = 1'b1;
        keys_in[2] = 1'b1;
        run(25);
        keys_in[4] = 1'b0;
        for (int i = 0; i < 40 && m_run[4] != 2; i++) step();
        check_val("run_at_2", 64'(m_run[4]), 64'd2);
        check_val("pend_before_rst", 64'(evt_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst_valid", 64'(evt_valid), 64'd0);
        check_val("rst_keys", 64'(keys_out), 64'(all_ones));
        check_val("rst_coal", 64'(coal), 64'd0);
        ready = 1'b1;
        run(30);
        check_val("rst_rekey", 64'(keys_out[4]), 64'd0);
        keys_in[4] = 1'b1;
        run(30);

        // coalesce counter saturation
        ready = 1'b0;
        for (int i = 0; i < 260; i++) begin
            keys_in[7] = ~keys_in[7];
            run(16);
        end
        check_val("coal_sat", 64'(coal), 64'd255);
        ready = 1'b1;
        keys_in[7] = 1'b1;
        run(30);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                idx = $urandom_range(0, 7);
                keys_in[idx] = ~keys_in[idx];
            end
            if ($urandom_range(0, 199) == 0) begin
                idx = $urandom_range(0, NK - 1);
                keys_in[idx] = ~keys_in[idx];
            end
            ready = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 61, number of key inputs (1..512).
REQ-002 SHALL have parameter TICK_DIV, default 780, clk_i cycles per sample tick (10 us at 78 MHz), range 2..65535.
REQ-003 SHALL have parameter STABLE_TICKS, default 4, consecutive differing ticks required to accept a new key level, range 1..255.
REQ-004 clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 keys_i  input  NUM_KEYS  raw key levels, asynchronous, active-low (1 = released).
REQ-007 keys_o  output  NUM_KEYS  debounced key levels, live, registered.
REQ-008 evt_valid_o  output  1  snapshot event pending.
REQ-009 evt_keys_o  output  NUM_KEYS  snapshot of keys_o, held stable while evt_valid_o=1.
REQ-010 evt_ready_i  input  1  downstream accepts the event.
REQ-011 evt_coalesced_o  output  8  saturating count of keys_o changes absorbed while an event was pending.

Function
REQ-012 Each keys_i bit SHALL pass through a 2-flop synchronizer before any other use; the synchronizer is the only logic sampling keys_i.
REQ-013 A free-running prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick is asserted for one cycle when the count equals TICK_DIV-1.
REQ-014 Per key, a stability counter of width ceil(log2(STABLE_TICKS+1)) SHALL be held.
REQ-015 On a tick, if synchronized bit equals keys_o bit, that key's counter SHALL clear to 0.
REQ-016 On a tick, if they differ and counter equals STABLE_TICKS-1, keys_o bit SHALL take the synchronized value on that clock edge and the counter SHALL clear to 0.
REQ-017 On a tick, if they differ and counter < STABLE_TICKS-1, the counter SHALL increment by 1.
REQ-018 Between ticks, counters and keys_o SHALL hold.
REQ-019 Consequently, a keys_i edge held stable SHALL reach keys_o 2 sync cycles plus STABLE_TICKS ticks later; a glitch shorter than one tick period before the STABLE_TICKS-th tick SHALL not reach keys_o.
REQ-020 Multiple keys updating on the same tick SHALL all update on the same edge and produce one event.
REQ-021 Event state machine SHALL have two states: IDLE (evt_valid_o=0) and PEND (evt_valid_o=1).
REQ-022 IDLE->PEND SHALL occur on the cycle after keys_o differs from evt_keys_o; evt_keys_o SHALL load keys_o on that transition.
REQ-023 In PEND, evt_keys_o SHALL not change.
REQ-024 Transfer SHALL occur on any cycle with evt_valid_o=1 and evt_ready_i=1; evt_valid_o SHALL not depend combinationally on evt_ready_i.
REQ-025 On transfer, if keys_o equals evt_keys_o, the state SHALL go to IDLE.
REQ-026 On transfer, if keys_o differs from evt_keys_o, including a keys_o update on the transfer edge itself, the state SHALL remain PEND and evt_keys_o SHALL load the current keys_o on the following cycle.
REQ-027 evt_valid_o SHALL be low for that single cycle.
REQ-028 evt_coalesced_o SHALL increment, saturating at 255, on each keys_o update edge that occurs while in PEND without a transfer on the same cycle.
REQ-029 evt_coalesced_o SHALL clear only on reset.
REQ-030 evt_ready_i while in IDLE SHALL have no effect.

Reset
REQ-031 While rst_i=1 on a clock edge, the block SHALL set synchronizer flops to all ones.
REQ-032 While rst_i=1 on a clock edge, the block SHALL set keys_o and evt_keys_o to all ones.
REQ-033 While rst_i=1 on a clock edge, the block SHALL clear the prescaler, all stability counters and evt_coalesced_o to 0.
REQ-034 While rst_i=1 on a clock edge, the block SHALL set the state to IDLE, so evt_valid_o=0.
REQ-035 Reset asserted mid-debounce or mid-handshake SHALL discard all progress; no event SHALL be generated by reset itself.

Verification (TICK_DIV=4, STABLE_TICKS=3, NUM_KEYS=61)
REQ-036 Reset, keys_i all ones for 100 cycles -> keys_o all ones, evt_valid_o never 1, evt_coalesced_o=0.
REQ-037 keys_i[5] 1->0 held -> keys_o[5]=0 on the 3rd tick after sync; evt_valid_o=1 the next cycle with evt_keys_o[5]=0; ready=1 -> IDLE.
REQ-038 keys_i[9] low for 6 cycles only -> keys_o unchanged, no event.
REQ-039 keys_i[0] and keys_i[60] fall in the same cycle -> both bits update on the same edge; exactly one event.
REQ-040 evt_ready_i=0; keys_i[1] falls, then keys_i[2] falls -> evt_keys_o shows only bit1 low and evt_coalesced_o=1; ready=1 -> valid drops 1 cycle, reasserts with bits 1,2 low.
REQ-041 rst_i pulsed while in PEND and a counter is at 2 -> next cycle evt_valid_o=0, keys_o all ones, and the key requires a full 3 new ticks to update.
